// File: rtl/phase_monitor_pkg.sv
// phase_monitor_pkg: phase encodings, successor function, FSM states and error codes
package phase_monitor_pkg;
  localparam logic [2:0] PH0 = 3'b000;
  localparam logic [2:0] PH1 = 3'b001;
  localparam logic [2:0] PH2 = 3'b010;
  localparam logic [2:0] PH3 = 3'b100;
  localparam logic [1:0] ERR_ENC  = 2'b01;
  localparam logic [1:0] ERR_TRN  = 2'b10;
  localparam logic [1:0] ERR_BOTH = 2'b11;
  typedef enum logic [1:0] {INIT, RUN, FAULT} state_t;
  function automatic logic [2:0] succ(input logic [2:0] s);
    return s == PH0 ? PH1 : s == PH1 ? PH2 : s == PH2 ? PH3 : PH0;
  endfunction
endpackage

// File: rtl/phase_monitor_idle_watchdog.sv
// idle_watchdog: counts consecutive en_in-low cycles (saturating) and flags starvation
//   clk, rst (async active-low), en_in: monitored enable; starve: idle count reached MAX_IDLE
module idle_watchdog #(
  parameter int MAX_IDLE = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic en_in,
  output logic starve
);
  logic [7:0] idle, idle_nxt;
  always_comb idle_nxt = en_in ? 8'd0 : idle == 8'(MAX_IDLE) ? idle : idle + 8'd1;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle   <= '0;
      starve <= 1'b0;
    end else begin
      idle   <= idle_nxt;
      starve <= idle_nxt == 8'(MAX_IDLE);
    end
  end
endmodule

// File: rtl/phase_monitor.sv
// phase_monitor: checks an upstream phase sequencer, reports wraps, protocol errors and starvation
//   clk, rst (async active-low); en_in, state_in: monitored sequencer enable and phase
//   wrap_valid/wrap_ready/wrap_data: wrap event handshake; wrap_ovf: sticky dropped-event flag
//   err/err_code: sticky first protocol error; starve: en_in idle for MAX_IDLE cycles
module phase_monitor
  import phase_monitor_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int MAX_IDLE = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_in,
  input  logic [2:0]       state_in,
  output logic             wrap_valid,
  input  logic             wrap_ready,
  output logic [CNT_W-1:0] wrap_data,
  output logic             wrap_ovf,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             starve
);
  state_t st, st_nxt;
  logic [2:0] prev_state;
  logic prev_en, enc_bad, trn_bad, bad, wrap, take;
  logic [CNT_W-1:0] cnt, cnt_inc;
  always_comb begin
    enc_bad = !(state_in inside {PH0, PH1, PH2, PH3});
    trn_bad = prev_en ? state_in != succ(prev_state) : state_in != prev_state;
    bad     = st == RUN && (enc_bad || trn_bad);
    // a 100->000 step under enable is always legal, so no error can coincide with a wrap
    wrap    = st == RUN && prev_en && prev_state == PH3 && state_in == PH0;
    take    = wrap_valid && wrap_ready;
    cnt_inc = cnt + CNT_W'(1);
    st_nxt  = st == INIT ? RUN : bad ? FAULT : st;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st         <= INIT;
      prev_state <= PH0;
      prev_en    <= 1'b0;
      cnt        <= '0;
      wrap_valid <= 1'b0;
      wrap_data  <= '0;
      wrap_ovf   <= 1'b0;
      err        <= 1'b0;
      err_code   <= '0;
    end else begin
      st <= st_nxt;
      if (st != FAULT) begin
        prev_state <= state_in;
        prev_en    <= en_in;
      end
      if (bad) begin
        err      <= 1'b1;
        err_code <= enc_bad && trn_bad ? ERR_BOTH : enc_bad ? ERR_ENC : ERR_TRN;
      end
      if (wrap) cnt <= cnt_inc;
      // a new wrap may replace the pending event only in the cycle it is being accepted
      if (wrap && (!wrap_valid || take)) begin
        wrap_valid <= 1'b1;
        wrap_data  <= cnt_inc;
      end else if (take) wrap_valid <= 1'b0;
      if (wrap && wrap_valid && !take) wrap_ovf <= 1'b1;
    end
  end
  idle_watchdog #(.MAX_IDLE(MAX_IDLE)) u_wd (
    .clk(clk),
    .rst(rst),
    .en_in(en_in),
    .starve(starve)
  );
endmodule

// File: tb/tb_phase_monitor.sv
// tb_phase_monitor: randomized and directed checks of phase_monitor against a behavioural model
module tb_phase_monitor;
  logic clk = 1'b0, rst = 1'b0, en_in = 1'b0, wrap_ready = 1'b0;
  logic [2:0] state_in = 3'b000;
  logic wrap_valid, wrap_ovf, err, starve;
  logic [7:0] wrap_data;
  logic [1:0] err_code;
  int tests = 0, fails = 0;
  int m_mode, m_pen, m_cnt, m_data, m_ovf, m_err, m_code, m_idle;
  logic [2:0] m_prev;
  int q[$];
  logic [2:0] loop_s[4] = '{3'b001, 3'b010, 3'b100, 3'b000};
  always #5 clk = ~clk;
  phase_monitor dut (
    .clk(clk), .rst(rst), .en_in(en_in), .state_in(state_in),
    .wrap_valid(wrap_valid), .wrap_ready(wrap_ready), .wrap_data(wrap_data),
    .wrap_ovf(wrap_ovf), .err(err), .err_code(err_code), .starve(starve)
  );
  function automatic logic [2:0] nxt_phase(input logic [2:0] s);
    return s == 3'b000 ? 3'b001 : {s[1:0], 1'b0};
  endfunction
  function automatic logic [13:0] expv();
    return {q.size() != 0, 8'(m_data), m_ovf[0], m_err[0], 2'(m_code), m_idle == 15};
  endfunction
  function automatic logic [13:0] actv();
    return {wrap_valid, wrap_data, wrap_ovf, err, err_code, starve};
  endfunction
  task automatic model_reset();
    m_mode = 0; m_pen = 0; m_prev = 3'b000; m_cnt = 0; m_data = 0;
    m_ovf = 0; m_err = 0; m_code = 0; m_idle = 0;
    q.delete();
  endtask
  task automatic model_clock();
    int enc, trn, wr;
    wr = 0;
    if (m_mode == 0) begin
      m_prev = state_in; m_pen = en_in; m_mode = 1;
    end else if (m_mode == 1) begin
      enc = int'($countones(state_in) > 1);
      trn = int'(m_pen != 0 ? state_in != nxt_phase(m_prev) : state_in != m_prev);
      if (enc + trn != 0) begin
        m_err = 1; m_code = 2 * trn + enc; m_mode = 2;
      end else wr = int'(m_pen != 0 && m_prev == 3'b100 && state_in == 3'b000);
      m_prev = state_in; m_pen = en_in;
    end
    if (q.size() != 0 && wrap_ready) q.delete();
    if (wr != 0) begin
      m_cnt = (m_cnt + 1) % 256;
      if (q.size() == 0) begin q.push_back(m_cnt); m_data = m_cnt; end
      else m_ovf = 1;
    end
    m_idle = en_in ? 0 : (m_idle < 15 ? m_idle + 1 : 15);
  endtask
  task automatic step(input logic e, input logic [2:0] s, input logic r);
    en_in = e; state_in = s; wrap_ready = r;
    @(posedge clk);
    model_clock();
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask
  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (actv() !== 14'h0) begin fails++; $display("FAIL reset_values: got %h expected %h", actv(), 14'h0); end
    rst = 1'b1;
    step(1'b0, 3'b000, 1'b0);
    tests++;
    if (actv() !== expv()) begin fails++; $display("FAIL reset_init: got %h expected %h", actv(), expv()); end
  endtask
  task automatic test_wrap_stream();
    do_reset();
    step(1'b1, 3'b000, 1'b1);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, loop_s[k % 4], 1'b1);
      tests++;
      if (actv() !== expv()) begin fails++; $display("FAIL wrap_stream cyc%0d: got %h expected %h", k, actv(), expv()); end
      if (k == 3 || k == 7) begin
        tests++;
        if ({wrap_valid, wrap_data, err} !== {1'b1, 8'(k / 4 + 1), 1'b0})
          begin fails++; $display("FAIL wrap_stream event%0d: got v=%b d=%0d e=%b expected v=1 d=%0d e=0", k / 4, wrap_valid, wrap_data, err, k / 4 + 1); end
      end
    end
  endtask
  task automatic test_overflow();
    do_reset();
    step(1'b1, 3'b000, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, loop_s[k % 4], 1'b0);
      tests++;
      if (actv() !== expv()) begin fails++; $display("FAIL overflow cyc%0d: got %h expected %h", k, actv(), expv()); end
    end
    tests++;
    if ({wrap_valid, wrap_data, wrap_ovf} !== {1'b1, 8'd1, 1'b1})
      begin fails++; $display("FAIL overflow hold: got v=%b d=%0d ovf=%b expected v=1 d=1 ovf=1", wrap_valid, wrap_data, wrap_ovf); end
    step(1'b1, 3'b001, 1'b1);
    tests++;
    if (wrap_valid !== 1'b0) begin fails++; $display("FAIL overflow drop: got v=%b expected v=0", wrap_valid); end
    step(1'b1, 3'b010, 1'b1);
    step(1'b1, 3'b100, 1'b1);
    step(1'b1, 3'b000, 1'b1);
    tests++;
    if ({wrap_valid, wrap_data, wrap_ovf} !== {1'b1, 8'd3, 1'b1})
      begin fails++; $display("FAIL overflow next: got v=%b d=%0d ovf=%b expected v=1 d=3 ovf=1", wrap_valid, wrap_data, wrap_ovf); end
  endtask
  task automatic test_enc_err();
    do_reset();
    step(1'b0, 3'b011, 1'b0);
    step(1'b0, 3'b011, 1'b0);
    tests++;
    if ({err, err_code} !== 3'b101) begin fails++; $display("FAIL enc_err code: got err=%b code=%b expected err=1 code=01", err, err_code); end
    for (int k = 0; k < 8; k++) begin
      step(1'b1, loop_s[(k + 3) % 4], 1'b1);
      tests++;
      if ({wrap_valid, err, err_code} !== 4'b0101 || actv() !== expv())
        begin fails++; $display("FAIL enc_err fault cyc%0d: got %h expected %h", k, actv(), expv()); end
    end
    do_reset();
    step(1'b1, 3'b000, 1'b0);
    step(1'b1, 3'b011, 1'b0);
    tests++;
    if ({err, err_code} !== 3'b111) begin fails++; $display("FAIL both_err code: got err=%b code=%b expected err=1 code=11", err, err_code); end
  endtask
  task automatic test_trn_err();
    do_reset();
    step(1'b0, 3'b001, 1'b0);
    step(1'b0, 3'b010, 1'b0);
    tests++;
    if ({err, err_code} !== 3'b110) begin fails++; $display("FAIL trn_err idle: got err=%b code=%b expected err=1 code=10", err, err_code); end
    step(1'b1, 3'b011, 1'b0);
    tests++;
    if ({err, err_code} !== 3'b110) begin fails++; $display("FAIL trn_err sticky: got err=%b code=%b expected err=1 code=10", err, err_code); end
    do_reset();
    step(1'b1, 3'b000, 1'b0);
    step(1'b1, 3'b001, 1'b0);
    step(1'b1, 3'b010, 1'b0);
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL trn_err legal: got err=%b expected err=0", err); end
    step(1'b1, 3'b001, 1'b0);
    tests++;
    if ({err, err_code} !== 3'b110) begin fails++; $display("FAIL trn_err back: got err=%b code=%b expected err=1 code=10", err, err_code); end
  endtask
  task automatic test_starve();
    do_reset();
    for (int k = 1; k <= 15; k++) begin
      step(1'b0, 3'b000, 1'b0);
      tests++;
      if (starve !== (k == 15)) begin fails++; $display("FAIL starve low%0d: got %b expected %b", k, starve, k == 15); end
    end
    step(1'b1, 3'b000, 1'b0);
    tests++;
    if (starve !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL starve clear: got starve=%b err=%b expected 0 0", starve, err); end
  endtask
  task automatic test_reset_mid();
    do_reset();
    step(1'b1, 3'b000, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b1, loop_s[k], 1'b0);
    tests++;
    if (wrap_valid !== 1'b1) begin fails++; $display("FAIL reset_mid pending: got v=%b expected v=1", wrap_valid); end
    #1 rst = 1'b0;
    model_reset();
    #1;
    tests++;
    if (actv() !== 14'h0) begin fails++; $display("FAIL reset_mid async: got %h expected %h", actv(), 14'h0); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    step(1'b0, 3'b010, 1'b1);
    step(1'b0, 3'b010, 1'b1);
    step(1'b1, 3'b010, 1'b1);
    step(1'b1, 3'b100, 1'b1);
    tests++;
    if (err !== 1'b0 || actv() !== expv()) begin fails++; $display("FAIL reset_mid init: got %h expected %h", actv(), expv()); end
  endtask
  task automatic test_cnt_wrap();
    do_reset();
    step(1'b1, 3'b000, 1'b1);
    for (int k = 1; k <= 256; k++) begin
      for (int j = 0; j < 4; j++) step(1'b1, loop_s[j], 1'b1);
      if (k >= 255) begin
        tests++;
        if (wrap_data !== 8'(k) || actv() !== expv())
          begin fails++; $display("FAIL cnt_wrap k%0d: got d=%0d expected d=%0d", k, wrap_data, k % 256); end
      end
    end
  endtask
  task automatic test_random();
    logic [2:0] s;
    logic e, r;
    for (int ep = 0; ep < 4; ep++) begin
      do_reset();
      s = loop_s[$urandom_range(0, 3)];
      e = 1'b1;
      step(e, s, 1'b0);
      for (int i = 0; i < 500; i++) begin
        s = e ? nxt_phase(s) : s;
        if ($urandom_range(0, 199) == 0) s = 3'($urandom_range(0, 7));
        e = ep == 2 ? $urandom_range(0, 7) == 0 : $urandom_range(0, 3) != 0;
        r = ep == 3 ? $urandom_range(0, 5) == 0 : $urandom_range(0, 1) == 1;
        step(e, s, r);
        tests++;
        if (actv() !== expv()) begin fails++; $display("FAIL random ep%0d cyc%0d: got %h expected %h", ep, i, actv(), expv()); end
      end
    end
  endtask
  initial begin
    test_reset();
    test_wrap_stream();
    test_overflow();
    test_enc_err();
    test_trn_err();
    test_starve();
    test_reset_mid();
    test_cnt_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
